// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch aligner
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  localparam int HW_W = 16;
  localparam logic [1:0] FULL_QUAD = 2'b11;
  localparam logic [31:0] WORD_INC = 32'd4;
  localparam logic [31:0] HW_INC = 32'd2;
  function automatic logic [31:0] align_pc(input logic [31:0] a, input logic rvc);
    return {a[31:2], rvc & a[1], 1'b0};
  endfunction
endpackage

// File: rtl/hw_queue.sv
// hw_queue: halfword FIFO accepting and releasing up to two parcels per cycle
module hw_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [1:0]              push_n,
  input  logic [HW_W-1:0]         push_d0,
  input  logic [HW_W-1:0]         push_d1,
  input  logic [1:0]              pop_n,
  output logic [$clog2(DEPTH):0]  count,
  output logic [HW_W-1:0]         peek0,
  output logic [HW_W-1:0]         peek1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [HW_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push_n);
      rp <= rp + PW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  always_ff @(posedge clk) begin
    if (rst_n && !clr && push_n != 2'd0) mem[wp] <= push_d0;
    if (rst_n && !clr && push_n[1]) mem[wp + PW'(1)] <= push_d1;
  end
  assign peek0 = mem[rp];
  assign peek1 = mem[rp + PW'(1)];
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: turns word fetches into whole 16/32-bit instructions with their PC.
// Compressed-instruction support is enabled by defining FETCH_RVC_EN.
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          HQ_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_c
);
  localparam int CW = $clog2(HQ_DEPTH) + 1;
`ifdef FETCH_RVC_EN
  localparam logic RVC = 1'b1;
`else
  localparam logic RVC = 1'b0;
`endif
  state_t state, state_nx;
  logic [31:0] pc, fetch_addr;
  logic skip_low, is_c, avail, fire, accept, resp;
  logic [1:0] push_n, pop_n;
  logic [CW-1:0] count;
  logic [HW_W-1:0] head, nxt;
  hw_queue #(.DEPTH(HQ_DEPTH)) u_queue (
    .clk(clk_in),
    .rst_n(rst_n_in),
    .clr(flush),
    .push_n(push_n),
    .push_d0(skip_low ? mem_data[31:16] : mem_data[15:0]),
    .push_d1(mem_data[31:16]),
    .pop_n(pop_n),
    .count(count),
    .peek0(head),
    .peek1(nxt)
  );
  always_comb begin
    is_c = RVC && count != '0 && head[1:0] != FULL_QUAD;
    avail = count >= (is_c ? CW'(1) : CW'(2));
    out_valid = avail && !flush;
    fire = out_valid && out_ready;
    pop_n = fire ? (is_c ? 2'd1 : 2'd2) : 2'd0;
    req_valid = rst_n_in && state == S_REQ && count <= CW'(HQ_DEPTH - 2);
    accept = req_valid && req_ready;
    resp = state == S_WAIT && mem_valid;
    push_n = (resp && !flush) ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
    out_is_c = avail && is_c;
    out_instr = !avail ? '0 : is_c ? {16'h0, head} : {nxt, head};
    req_addr = fetch_addr;
    out_pc = pc;
  end
  // A response still in flight after a redirect must be swallowed in S_DROP
  always_comb begin
    state_nx = state;
    if (flush)
      state_nx = ((state == S_REQ && accept) || (state != S_REQ && !mem_valid)) ? S_DROP : S_REQ;
    else if (state == S_REQ)
      state_nx = accept ? S_WAIT : S_REQ;
    else if (mem_valid)
      state_nx = S_REQ;
  end
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      state <= S_REQ;
      pc <= align_pc(RESET_PC, RVC);
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      skip_low <= RVC & RESET_PC[1];
    end else begin
      state <= state_nx;
      if (flush) begin
        pc <= align_pc(flush_pc, RVC);
        fetch_addr <= {flush_pc[31:2], 2'b00};
        skip_low <= RVC & flush_pc[1];
      end else begin
        if (fire) pc <= pc + (is_c ? HW_INC : WORD_INC);
        if (resp) begin
          fetch_addr <= fetch_addr + WORD_INC;
          skip_low <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: randomized cache responder plus a memory-image instruction model
module tb_fetch_aligner;
  logic clk_in = 0, rst_n_in = 0, req_ready = 0, mem_valid = 0, flush = 0, out_ready = 0;
  logic req_valid, out_valid, out_is_c;
  logic [31:0] req_addr, out_instr, out_pc, mem_data = 0, flush_pc = 0;
  int checks = 0, fails = 0;
  int lat = 0;
  bit rdy_rand = 0;
  logic [31:0] seed;
  logic [31:0] ovr [logic [31:0]];
  bit pend = 0;
  logic [31:0] pend_addr = 0;
  int pend_cnt = 0;
`ifdef FETCH_RVC_EN
  localparam bit RVC = 1;
`else
  localparam bit RVC = 0;
`endif

  always #5 clk_in = ~clk_in;

  fetch_aligner dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_is_c(out_is_c)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ovr.exists(w) ? ovr[w] : (w * 32'h9E37_79B1) ^ seed ^ {w[15:0], w[31:16]};
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] start_pc(input logic [31:0] a);
    return RVC ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
  endfunction

  // Instruction at pc read straight out of the memory image
  task automatic model(input logic [31:0] pc, output logic [31:0] instr, output logic c,
                       output logic [31:0] npc);
    logic [15:0] lo;
    lo = hw_at(pc);
    c = RVC && lo[1:0] != 2'b11;
    instr = c ? {16'h0, lo} : {hw_at(pc + 32'd2), lo};
    npc = pc + (c ? 32'd2 : 32'd4);
  endtask

  // Cache: one response per accepted request, lat cycles later
  initial forever begin
    @(negedge clk_in);
    mem_valid = 0;
    if (!rst_n_in) pend = 0;
    else if (pend) begin
      if (pend_cnt == 0) begin
        mem_valid = 1;
        mem_data = word_at(pend_addr);
        pend = 0;
      end else pend_cnt--;
    end
    req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n_in && req_valid && req_ready) begin
      pend = 1;
      pend_addr = req_addr;
      pend_cnt = lat;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pull(output logic [31:0] pc, output logic [31:0] instr, output logic c,
                      output bit ok);
    ok = 0; pc = '0; instr = '0; c = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_in);
      if (out_valid) begin
        pc = out_pc; instr = out_instr; c = out_is_c; ok = 1;
        out_ready = 1;
        @(posedge clk_in);
        #1 out_ready = 0;
      end
    end
  endtask

  task automatic do_flush(input logic [31:0] pc);
    @(negedge clk_in);
    flush = 1; flush_pc = pc;
    @(negedge clk_in);
    flush = 0;
  endtask

  task automatic test_reset;
    rst_n_in = 0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (req_addr !== 32'h0) begin fails++; $display("FAIL reset_req_addr: got %h want 0", req_addr); end
    checks++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    checks++; if ({out_instr, out_is_c} !== 33'h0) begin fails++; $display("FAIL reset_out_instr: got %h/%b want 0", out_instr, out_is_c); end
    rst_n_in = 1;
    @(negedge clk_in); #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin fails++; $display("FAIL first_req: got valid=%b addr=%h want 1/0", req_valid, req_addr); end
  endtask

  task automatic test_basic;
    logic [31:0] ep, ei, np, op, oi; logic ec, oc; bit ok;
    ep = 32'h0;
    for (int k = 0; k < 2; k++) begin
      model(ep, ei, ec, np);
      pull(op, oi, oc, ok);
      checks++;
      if (!ok || op !== ep || oi !== ei || oc !== ec) begin
        fails++;
        $display("FAIL basic[%0d]: got ok=%b pc=%h instr=%h c=%b want pc=%h instr=%h c=%b", k, ok, op, oi, oc, ep, ei, ec);
      end
      ep = np;
    end
  endtask

  task automatic test_flush_wait;
    logic [31:0] ep, ei, np, op, oi; logic ec, oc; bit ok, found;
    lat = 20; rdy_rand = 0;
    ovr[32'h100] = 32'hABCD_0001;
    do_flush(32'h200);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_in); #1;
      found = req_valid && req_ready;
    end
    checks++; if (!found) begin fails++; $display("FAIL flush_wait_setup: got no request want one"); end
    @(negedge clk_in);
    flush = 1; flush_pc = 32'h0000_0102;
    @(negedge clk_in);
    flush = 0; lat = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_in); #1;
      found = req_valid;
    end
    checks++;
    if (!found || req_addr !== 32'h100) begin fails++; $display("FAIL flush_wait_addr: got found=%b addr=%h want 1/00000100", found, req_addr); end
    ep = start_pc(32'h102);
    model(ep, ei, ec, np);
    pull(op, oi, oc, ok);
    checks++;
    if (!ok || op !== ep || oi !== ei || oc !== ec) begin
      fails++;
      $display("FAIL flush_wait_instr: got ok=%b pc=%h instr=%h c=%b want pc=%h instr=%h c=%b", ok, op, oi, oc, ep, ei, ec);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ep, ei, np, op, oi; logic ec, oc; bit ok; int rv;
    lat = 0; rdy_rand = 1;
    do_flush(32'h300);
    repeat (40) @(negedge clk_in);
    rv = 0;
    repeat (10) begin @(negedge clk_in); #1; rv += int'(req_valid); end
    checks++; if (rv != 0) begin fails++; $display("FAIL bp_req_valid: got %0d requesting cycles want 0", rv); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    ep = start_pc(32'h300);
    for (int k = 0; k < 8; k++) begin
      model(ep, ei, ec, np);
      pull(op, oi, oc, ok);
      checks++;
      if (!ok || op !== ep || oi !== ei || oc !== ec) begin
        fails++;
        $display("FAIL bp[%0d]: got ok=%b pc=%h instr=%h c=%b want pc=%h instr=%h c=%b", k, ok, op, oi, oc, ep, ei, ec);
      end
      ep = np;
    end
  endtask

  task automatic test_flush_same_cycle;
    logic [31:0] ep, ei, np, op, oi; logic ec, oc; bit ok, found;
    lat = 3; rdy_rand = 0;
    do_flush(32'h400);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_in); #1;
      found = mem_valid && out_valid;
    end
    checks++; if (!found) begin fails++; $display("FAIL same_cycle_setup: got no overlap want mem_valid with out_valid"); end
    flush = 1; flush_pc = 32'h500; out_ready = 1;
    @(negedge clk_in);
    flush = 0; out_ready = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL same_cycle_empty: got out_valid=%b want 0", out_valid); end
    ep = start_pc(32'h500);
    for (int k = 0; k < 4; k++) begin
      model(ep, ei, ec, np);
      pull(op, oi, oc, ok);
      checks++;
      if (!ok || op !== ep || oi !== ei || oc !== ec) begin
        fails++;
        $display("FAIL same_cycle[%0d]: got ok=%b pc=%h instr=%h c=%b want pc=%h instr=%h c=%b", k, ok, op, oi, oc, ep, ei, ec);
      end
      ep = np;
    end
  endtask

`ifdef FETCH_RVC_EN
  task automatic test_rvc;
    logic [31:0] xp [5] = '{32'h700, 32'h702, 32'h600, 32'h602, 32'h606};
    logic [31:0] xi [5] = '{32'h1, 32'h4505, 32'h1, 32'h0050_0513, 32'h1234};
    logic xc [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] op, oi; logic oc; bit ok;
    ovr[32'h700] = 32'h4505_0001;
    ovr[32'h600] = 32'h0513_0001;
    ovr[32'h604] = 32'h1234_0050;
    lat = 1; rdy_rand = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) do_flush(32'h700);
      if (k == 2) do_flush(32'h600);
      pull(op, oi, oc, ok);
      checks++;
      if (!ok || op !== xp[k] || oi !== xi[k] || oc !== xc[k]) begin
        fails++;
        $display("FAIL rvc[%0d]: got ok=%b pc=%h instr=%h c=%b want pc=%h instr=%h c=%b", k, ok, op, oi, oc, xp[k], xi[k], xc[k]);
      end
    end
  endtask
`else
  task automatic test_no_rvc;
    logic [31:0] op, oi; logic oc; bit ok;
    ovr[32'h600] = 32'h0513_0001;
    lat = 1; rdy_rand = 1;
    do_flush(32'h602);
    pull(op, oi, oc, ok);
    checks++;
    if (!ok || op !== 32'h600 || oi !== 32'h0513_0001 || oc !== 1'b0) begin
      fails++;
      $display("FAIL no_rvc: got ok=%b pc=%h instr=%h c=%b want pc=00000600 instr=05130001 c=0", ok, op, oi, oc);
    end
  endtask
`endif

  task automatic test_random;
    logic [31:0] ep, ei, np, op, oi, fpc; logic ec, oc; bit ok;
    for (int r = 0; r < 8; r++) begin
      fpc = (r == 0) ? (32'hFFFF_FFF4 | ($urandom & 32'h2)) : $urandom;
      lat = $urandom_range(0, 3);
      rdy_rand = 1;
      do_flush(fpc);
      ep = start_pc(fpc);
      for (int k = 0; k < 16; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_in);
        model(ep, ei, ec, np);
        pull(op, oi, oc, ok);
        checks++;
        if (!ok || op !== ep || oi !== ei || oc !== ec) begin
          fails++;
          $display("FAIL random[%0d.%0d]: got ok=%b pc=%h instr=%h c=%b want pc=%h instr=%h c=%b", r, k, ok, op, oi, oc, ep, ei, ec);
        end
        ep = np;
      end
    end
  endtask

  initial begin
    seed = $urandom;
    ovr[32'h0] = 32'h0000_0013;
    ovr[32'h4] = 32'h0010_0093;
    test_reset;
    test_basic;
    test_flush_wait;
    test_backpressure;
    test_flush_same_cycle;
`ifdef FETCH_RVC_EN
    test_rvc;
`else
    test_no_rvc;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch aligner directly upstream of the decompression stage.
- Requests word-aligned 32-bit words from the instruction cache and buffers them as 16-bit parcels.
- Presents one complete raw instruction per handshake (16-bit compressed or 32-bit) with its PC.
- Handles instructions straddling word boundaries and halfword-aligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored.
- HQ_DEPTH, 4, parcel queue depth in halfwords; power of two, at least 4.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, synchronous, active-low
- req_valid  output  1  word fetch request
- req_addr  output  32  request address, bits[1:0] always 00
- req_ready  input  1  cache accepts request this cycle
- mem_valid  input  1  response word valid, one cycle
- mem_data  input  32  response word, little-endian halfwords
- flush  input  1  redirect (branch/jump/exception)
- flush_pc  input  32  redirect target, bit 0 ignored
- out_valid  output  1  instruction available
- out_ready  input  1  downstream accepts
- out_instr  output  32  raw instruction; upper 16 bits zero when compressed
- out_pc  output  32  PC of out_instr
- out_is_c  output  1  out_instr is 16-bit

Behaviour:
- Reset (rst_n_in low at a clock edge):
  - Queue emptied; state S_REQ.
  - pc = RESET_PC with bit 0 cleared; fetch_addr = {RESET_PC[31:2],00}; skip_low = RESET_PC[1].
  - All outputs low except req_addr = fetch_addr and out_pc = pc.
  - Reset mid-request abandons the request; a later stale mem_valid is not expected.
- State machine: one outstanding request maximum.
  - S_REQ: req_valid = 1 when free entries ≥ 2. On req_valid && req_ready, go to S_WAIT.
  - S_WAIT: on mem_valid:
    - Push lower halfword then upper halfword.
    - If skip_low is set, push the upper halfword only and clear skip_low.
    - fetch_addr += 4; return to S_REQ.
  - S_DROP: wait for mem_valid, discard the data, go to S_REQ.
- Output rules:
  - Head parcel with bits[1:0] != 11 is compressed: needs 1 entry, out_instr = {16'h0, head}, out_is_c = 1.
  - Otherwise needs 2 entries, out_instr = {entry1, head}, out_is_c = 0.
  - out_valid = enough entries && !flush. Outputs are combinational from queue contents, zero latency.
  - On out_valid && out_ready: pop 1 or 2 entries; pc += 2 or 4.
- Push and pop in the same cycle are both applied with net occupancy. The free-entry check uses the pre-pop count.
- Flush has highest priority in any state:
  - Queue cleared; pc = {flush_pc[31:1],0}; fetch_addr = {flush_pc[31:2],00}; skip_low = flush_pc[1].
  - S_WAIT, or S_REQ with req_valid && req_ready in the flush cycle, goes to S_DROP; otherwise goes to S_REQ.
  - A mem_valid in the flush cycle is discarded.
  - A request not yet accepted is withdrawn: req_valid low the next cycle.
- Wrap-around: fetch_addr and pc wrap modulo 2^32. Queue pointers wrap modulo HQ_DEPTH.
- Straddling 32-bit instruction (pc[1] = 1): out_valid stays low until the next word's lower parcel is pushed.

Optional Feature:
- FETCH_RVC_EN defined:
  - Compressed support as above.
- FETCH_RVC_EN undefined:
  - Every instruction is treated as 32-bit; out_is_c is tied 0.
  - flush_pc[1] and RESET_PC[1] are ignored; skip_low is never set.
  - Always pops 2 entries; pc += 4.

Decomposition:
- Package fetch_pkg:
  - State enum S_REQ/S_WAIT/S_DROP.
  - HW_W = 16.
  - Full-length quadrant constant 2'b11.
  - Word/halfword increment constants.
- One sub-module: hw_queue, a parameterised halfword FIFO.
  - Push of 0/1/2 entries; pop of 0/1/2 entries; count output; peek of entries 0 and 1.
  - Synchronous active-low clear plus a flush clear.

Test Plan:
- Reset with RESET_PC = 0; words 0x00000013 at address 0, 0x00100093 at address 4 -> out_instr 0x00000013 at pc 0, then 0x00100093 at pc 4, out_is_c = 0.
- Word 0x4505_0001 at address 0 -> out_instr 0x0000_0001 at pc 0, then 0x0000_4505 at pc 2, out_is_c = 1 for both.
- Straddle: word 0x0513_0001 at 0, word 0x1234_0050 at 4 -> pc 0 compressed 0x0001; pc 2 out_instr 0x0050_0513; pc 6 compressed 0x1234.
- Flush to 0x0000_0102 while S_WAIT -> old response dropped; next req_addr 0x100; response 0xABCD_0001 -> first out_pc 0x102 with out_instr 0x0000_ABCD.
- out_ready held low with 4 parcels queued -> req_valid stays 0 and no overflow; release out_ready -> instructions in order and fetch resumes.
- Flush in the same cycle as mem_valid and out_ready -> no pop and no push take effect; queue empty the next cycle.
